// File: rtl/font_rom_scheduler_if.sv
// Bus bundle between the font ROM scheduler, its two requesters and the font ROM.
// The scheduler takes the slave view; the requesters and ROM take the master view.
interface font_rom_scheduler_if #(
  parameter int unsigned CHAR_W = 7,
  parameter int unsigned ROW_W  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
);
  logic              rt_req;
  logic [ADDR_W-1:0] rt_addr;
  logic              rt_valid;
  logic [DATA_W-1:0] rt_data;
  logic              bk_start;
  logic [CHAR_W-1:0] bk_char;
  logic              bk_busy;
  logic              bk_row_valid;
  logic [ROW_W-1:0]  bk_row_idx;
  logic [DATA_W-1:0] bk_row_data;
  logic              bk_done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  rt_req, rt_addr, bk_start, bk_char, rom_data,
    output rt_valid, rt_data, bk_busy, bk_row_valid, bk_row_idx, bk_row_data, bk_done, rom_addr
  );

  modport master (
    output rt_req, rt_addr, bk_start, bk_char, rom_data,
    input  rt_valid, rt_data, bk_busy, bk_row_valid, bk_row_idx, bk_row_data, bk_done, rom_addr
  );
endinterface

// File: rtl/font_rom_scheduler.sv
// Shares one synchronous font ROM between the real-time renderer (absolute priority,
// zero added latency) and a background engine that fetches all 16 rows of a glyph.
module font_rom_scheduler #(
  parameter int unsigned CHAR_W = 7,
  parameter int unsigned ROW_W  = 4,
  parameter int unsigned DATA_W = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  font_rom_scheduler_if.slave  bus
);
  localparam int unsigned AddrW = 10;
  localparam int unsigned CharAddrW = AddrW - ROW_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [1:0] OwnNone = 2'd0;
  localparam logic [1:0] OwnRt   = 2'd1;
  localparam logic [1:0] OwnBk   = 2'd2;

  localparam logic [ROW_W-1:0] LastRow = '1;

  logic [1:0]        r_state, w_state_d;
  logic [CHAR_W-1:0] r_char, w_char_d;
  logic [ROW_W-1:0]  r_row_cnt, w_row_cnt_d;
  logic [1:0]        r_owner, w_owner_d;
  logic [ROW_W-1:0]  r_tag_row, w_tag_row_d;
  logic              w_bk_issue;
  logic              w_unused_char;

  // The default ROM is 10 bits deep, so only the low char bits reach the address.
  assign w_unused_char = ^r_char;

  assign w_bk_issue = (r_state == StFetch) && !bus.rt_req;

  always_comb begin
    bus.rom_addr = '0;
    if (bus.rt_req) begin
      bus.rom_addr = bus.rt_addr;
    end else if (r_state == StFetch) begin
      bus.rom_addr = {r_char[CharAddrW-1:0], r_row_cnt};
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_char_d    = r_char;
    w_row_cnt_d = r_row_cnt;
    case (r_state)
      StIdle: begin
        if (bus.bk_start) begin
          w_state_d   = StFetch;
          w_char_d    = bus.bk_char;
          w_row_cnt_d = '0;
        end
      end
      StFetch: begin
        // Renderer owns the slot while rt_req is high; the row counter simply waits.
        if (!bus.rt_req) begin
          w_row_cnt_d = r_row_cnt + 1'b1;
          if (r_row_cnt == LastRow) begin
            w_state_d = StDrain;
          end
        end
      end
      StDrain: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_owner_d   = OwnNone;
    w_tag_row_d = '0;
    if (bus.rt_req) begin
      w_owner_d = OwnRt;
    end else if (w_bk_issue) begin
      w_owner_d   = OwnBk;
      w_tag_row_d = r_row_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_char    <= '0;
      r_row_cnt <= '0;
      r_owner   <= OwnNone;
      r_tag_row <= '0;
    end else begin
      r_state   <= w_state_d;
      r_char    <= w_char_d;
      r_row_cnt <= w_row_cnt_d;
      r_owner   <= w_owner_d;
      r_tag_row <= w_tag_row_d;
    end
  end

  assign bus.rt_valid     = (r_owner == OwnRt);
  assign bus.rt_data      = bus.rom_data;
  assign bus.bk_busy      = (r_state != StIdle);
  assign bus.bk_row_valid = (r_owner == OwnBk);
  assign bus.bk_row_idx   = r_tag_row;
  assign bus.bk_row_data  = bus.rom_data;
  assign bus.bk_done      = (r_state == StDrain);
endmodule

// File: tb/tb_font_rom_scheduler.sv
// Bench for font_rom_scheduler: directed per-cycle tables, reset corner cases and a
// randomized run against a slot-level reference model of the ROM sharing rules.
module tb_font_rom_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  font_rom_scheduler_if bus ();

  font_rom_scheduler #(.CHAR_W(7), .ROW_W(4), .DATA_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] rom_mem [1024];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.rt_req   = 1'b0;
    bus.rt_addr  = '0;
    bus.bk_start = 1'b0;
    bus.bk_char  = '0;
  endtask

  // Enters anywhere, leaves at posedge+1 with the DUT idle; that cycle is "cycle 0".
  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rt_req   = 1'($urandom_range(0, 1));
      bus.rt_addr  = 10'($urandom);
      bus.bk_start = 1'($urandom_range(0, 1));
      bus.bk_char  = 7'($urandom);
      @(negedge clk);
      chk("rst.rt_valid", 32'(bus.rt_valid), 32'd0);
      chk("rst.bk_busy", 32'(bus.bk_busy), 32'd0);
      chk("rst.bk_row_valid", 32'(bus.bk_row_valid), 32'd0);
      chk("rst.bk_row_idx", 32'(bus.bk_row_idx), 32'd0);
      chk("rst.bk_done", 32'(bus.bk_done), 32'd0);
      chk("rst.rom_addr", 32'(bus.rom_addr), bus.rt_req ? 32'(bus.rt_addr) : 32'd0);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel.rt_valid", 32'(bus.rt_valid), 32'd0);
    chk("rel.bk_busy", 32'(bus.bk_busy), 32'd0);
    chk("rel.bk_row_valid", 32'(bus.bk_row_valid), 32'd0);
    chk("rel.bk_done", 32'(bus.bk_done), 32'd0);
    chk("rel.rom_addr", 32'(bus.rom_addr), 32'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rt_req;
    logic [9:0] rt_addr;
    logic       bk_start;
    logic [6:0] bk_char;
    logic [9:0] e_addr;
    logic       e_rt_valid;
    logic       e_bk_valid;
    logic [3:0] e_idx;
    logic [6:0] e_char;
    logic       e_done;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic run_table(input string tag);
    logic [9:0] prev_rt_addr = '0;
    foreach (tbl[i]) begin
      bus.rt_req   = tbl[i].rt_req;
      bus.rt_addr  = tbl[i].rt_addr;
      bus.bk_start = tbl[i].bk_start;
      bus.bk_char  = tbl[i].bk_char;
      @(negedge clk);
      chk($sformatf("%s.rom_addr[c%0d]", tag, i), 32'(bus.rom_addr), 32'(tbl[i].e_addr));
      chk($sformatf("%s.rt_valid[c%0d]", tag, i), 32'(bus.rt_valid), 32'(tbl[i].e_rt_valid));
      chk($sformatf("%s.bk_row_valid[c%0d]", tag, i), 32'(bus.bk_row_valid),
          32'(tbl[i].e_bk_valid));
      chk($sformatf("%s.bk_busy[c%0d]", tag, i), 32'(bus.bk_busy), 32'(tbl[i].e_busy));
      chk($sformatf("%s.bk_done[c%0d]", tag, i), 32'(bus.bk_done), 32'(tbl[i].e_done));
      if (tbl[i].e_bk_valid) begin
        chk($sformatf("%s.bk_row_idx[c%0d]", tag, i), 32'(bus.bk_row_idx), 32'(tbl[i].e_idx));
        chk($sformatf("%s.bk_row_data[c%0d]", tag, i), 32'(bus.bk_row_data),
            32'(rom_mem[{tbl[i].e_char[5:0], tbl[i].e_idx}]));
      end
      if (tbl[i].e_rt_valid) begin
        chk($sformatf("%s.rt_data[c%0d]", tag, i), 32'(bus.rt_data), 32'(rom_mem[prev_rt_addr]));
      end
      if (tbl[i].rt_req) prev_rt_addr = tbl[i].rt_addr;
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic build_rt_only();
    vec_t v;
    tbl.delete();
    for (int c = 0; c < 6; c++) begin
      v = blank();
      v.rt_req     = 1'b1;
      v.rt_addr    = 10'h3A5;
      v.e_addr     = 10'h3A5;
      v.e_rt_valid = (c >= 1);
      tbl.push_back(v);
    end
  endtask

  // Burst of 0x21 at cycle 0, ignored start at 10, accepted start (0x05) at 18.
  task automatic build_clean();
    vec_t v;
    tbl.delete();
    for (int c = 0; c < 20; c++) begin
      v = blank();
      v.bk_start = (c == 0) || (c == 10) || (c == 18);
      v.bk_char  = (c == 0) ? 7'h21 : 7'h05;
      if (c >= 1 && c <= 16) v.e_addr = 10'h210 + 10'(c - 1);
      if (c == 19) v.e_addr = 10'h050;
      v.e_bk_valid = (c >= 2 && c <= 17);
      v.e_idx      = 4'(c - 2);
      v.e_char     = 7'h21;
      v.e_done     = (c == 17);
      v.e_busy     = (c >= 1 && c <= 17) || (c == 19);
      tbl.push_back(v);
    end
  endtask

  // Same burst with rt_req in cycles 4..7: rows 3..15 slip by four cycles.
  task automatic build_interleave();
    vec_t v;
    tbl.delete();
    for (int c = 0; c < 23; c++) begin
      v = blank();
      v.bk_start = (c == 0);
      v.bk_char  = 7'h21;
      v.rt_req   = (c >= 4 && c <= 7);
      v.rt_addr  = v.rt_req ? 10'h3A5 + 10'(c) : 10'h0;
      if (v.rt_req) v.e_addr = v.rt_addr;
      else if (c >= 1 && c <= 3) v.e_addr = 10'h210 + 10'(c - 1);
      else if (c >= 8 && c <= 20) v.e_addr = 10'h210 + 10'(c - 5);
      v.e_rt_valid = (c >= 5 && c <= 8);
      v.e_bk_valid = (c >= 2 && c <= 4) || (c >= 9 && c <= 21);
      v.e_idx      = (c <= 4) ? 4'(c - 2) : 4'(c - 6);
      v.e_char     = 7'h21;
      v.e_done     = (c == 21);
      v.e_busy     = (c >= 1 && c <= 21);
      tbl.push_back(v);
    end
  endtask

  task automatic reset_mid_burst();
    bus.bk_start = 1'b1;
    bus.bk_char  = 7'h21;
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("midrst.busy_before", 32'(bus.bk_busy), 32'd1);
    chk("midrst.row_valid_before", 32'(bus.bk_row_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst.busy_drop", 32'(bus.bk_busy), 32'd0);
    chk("midrst.row_valid_drop", 32'(bus.bk_row_valid), 32'd0);
    chk("midrst.done_in_rst", 32'(bus.bk_done), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst.done_after", 32'(bus.bk_done), 32'd0);
    chk("midrst.busy_after", 32'(bus.bk_busy), 32'd0);
    @(posedge clk);
    #1;
    build_clean();
    run_table("after_midrst");
  endtask

  // Slot-level model: each cycle the ROM slot goes to rt, else to the next pending burst row;
  // whatever was issued comes back one cycle later; done follows the cycle the 16th row went out.
  task automatic random_run(input int cycles);
    bit         m_on = 1'b0;
    int         m_rows = 0;
    logic [6:0] m_char = '0;
    int         last_kind = 0;
    logic [9:0] last_addr = '0;
    int         last_row = 0;
    int         kind;
    logic [9:0] addr;
    for (int n = 0; n < cycles; n++) begin
      bus.rt_req   = ($urandom_range(0, 99) < 35);
      bus.rt_addr  = 10'($urandom);
      bus.bk_start = ($urandom_range(0, 9) == 0);
      bus.bk_char  = 7'($urandom);
      @(negedge clk);
      if (bus.rt_req) begin
        kind = 1;
        addr = bus.rt_addr;
      end else if (m_on && m_rows < 16) begin
        kind = 2;
        addr = {m_char[5:0], 4'(m_rows)};
      end else begin
        kind = 0;
        addr = '0;
      end
      chk("rnd.rom_addr", 32'(bus.rom_addr), 32'(addr));
      chk("rnd.rt_valid", 32'(bus.rt_valid), 32'(last_kind == 1));
      chk("rnd.bk_row_valid", 32'(bus.bk_row_valid), 32'(last_kind == 2));
      chk("rnd.bk_busy", 32'(bus.bk_busy), 32'(m_on));
      chk("rnd.bk_done", 32'(bus.bk_done), 32'(m_on && m_rows == 16));
      chk("rnd.exclusive", 32'(bus.rt_valid && bus.bk_row_valid), 32'd0);
      if (last_kind == 1) chk("rnd.rt_data", 32'(bus.rt_data), 32'(rom_mem[last_addr]));
      if (last_kind == 2) begin
        chk("rnd.bk_row_idx", 32'(bus.bk_row_idx), 32'(last_row));
        chk("rnd.bk_row_data", 32'(bus.bk_row_data), 32'(rom_mem[last_addr]));
      end
      last_kind = kind;
      last_addr = addr;
      last_row  = m_rows;
      if (m_on && m_rows == 16) begin
        m_on = 1'b0;
      end else if (m_on) begin
        if (kind == 2) m_rows++;
      end else if (bus.bk_start) begin
        m_on   = 1'b1;
        m_rows = 0;
        m_char = bus.bk_char;
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'($urandom);
    idle_inputs();
    do_reset();
    build_rt_only();
    run_table("rt_only");
    do_reset();
    build_clean();
    run_table("clean");
    do_reset();
    build_interleave();
    run_table("interleave");
    do_reset();
    reset_mid_burst();
    do_reset();
    random_run(3000);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/font_rom_scheduler.md
# font_rom_scheduler

Shares the single 1024x8 synchronous font ROM between two requesters. The real-time text renderer reads every pixel clock and must keep exactly the latency of a direct ROM connection. A background glyph-burst engine fetches all 16 rows of one character into idle ROM slots for console or cursor blitters. The block sits between the video text path, the blitter logic and the font ROM instance, and owns the ROM address bus.

## Interface
Parameters:
- CHAR_W, 7, character code width (128 glyphs)
- ROW_W, 4, glyph row index width (16 rows); ROM address width = CHAR_W+ROW_W = 11? no: fixed 10-bit as {char[6:0], row[3:0]} truncated by ROM to 10 LSBs; keep CHAR_W+ROW_W = 11 only if the ROM is widened, default build uses the ROM's 10-bit addr = {char[5:0], row}
- DATA_W, 8, font word width

Ports:
- clk  in  1  system/pixel clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- rt_req  in  1  real-time read request this cycle (absolute priority)
- rt_addr  in  10  real-time ROM address {char, row}
- rt_valid  out  1  rt_data holds the word for the rt_req of the previous cycle
- rt_data  out  DATA_W  ROM data to renderer (passthrough of rom_data)
- bk_start  in  1  start glyph burst; sampled only when bk_busy=0
- bk_char  in  CHAR_W  glyph code, captured with bk_start
- bk_busy  out  1  burst in progress
- bk_row_valid  out  1  bk_row_data/bk_row_idx valid this cycle
- bk_row_idx  out  ROW_W  row number of returned word
- bk_row_data  out  DATA_W  returned glyph row
- bk_done  out  1  one-cycle pulse with the final row (row 15)
- rom_addr  out  10  address to font ROM (combinational mux)
- rom_data  in  DATA_W  ROM output, valid one cycle after rom_addr

## Operation
- rom_addr = rt_addr when rt_req=1, else {char_q, row_cnt} when state=FETCH, else 0. Combinational, so the renderer sees 1-cycle latency as if direct.
- Issue tag register owner_q ∈ {NONE, RT, BK} plus tag_row_q, loaded every cycle with the owner of that cycle's rom_addr. rt_valid = (owner_q==RT). bk_row_valid = (owner_q==BK). bk_row_idx = tag_row_q. rt_data = bk_row_data = rom_data.
- FSM:
  - IDLE: bk_busy=0. On bk_start, capture char_q, row_cnt←0, go to FETCH.
  - FETCH: in each cycle with rt_req=0, issue row_cnt and increment it. After issuing row 15 (with rt_req=0), go to DRAIN. While rt_req=1, nothing is issued and row_cnt holds.
  - DRAIN: one cycle. The row-15 word returns, bk_done=1, then IDLE.
- bk_start while bk_busy=1 is ignored. No queueing.
- Rows are issued strictly in order 0..15, with no duplicates and no skips, regardless of rt_req gaps.
- The renderer is never stalled. The burst may be starved indefinitely by continuous rt_req, which is intended: bursts complete in blanking.

## Timing
- Reset (async, reset_n=0): state IDLE, row_cnt=0, char_q=0, owner_q=NONE. All outputs are 0: rt_valid, bk_busy, bk_row_valid, bk_row_idx, bk_done. rom_addr=0 unless rt_req=1. Reset mid-burst abandons the burst with no bk_done.
- Let bk_start be sampled at edge 0. bk_busy=1 from cycle 1 through the bk_done cycle inclusive.
- Without rt traffic:
  - Row n is issued in cycle 1+n and returns in cycle 2+n.
  - Row 15 returns in cycle 17, with bk_done=1 in cycle 17.
  - bk_busy=0 in cycle 18, and a new bk_start is accepted in cycle 18.
- Each cycle of rt_req=1 during FETCH delays all remaining rows by one cycle.
- rt_req=1 in cycle k gives rt_valid=1 in cycle k+1, always.
- bk_start and rt_req in the same cycle: the start is accepted, and the first issue slot is the next cycle with rt_req=0.
- rt_valid and bk_row_valid are never high in the same cycle.

## Test plan
- Reset: hold reset_n=0 with random inputs, then release → all outputs 0; rt_req first honoured on the following cycle.
- Real-time only: rt_req=1 every cycle with rt_addr=0x3A5 → rom_addr=0x3A5 the same cycle; rt_valid=1 and rt_data=ROM[0x3A5] next cycle; bk_* stay 0.
- Clean burst: bk_start with bk_char=0x21 at edge 0 → rom_addr=0x210..0x21F in cycles 1..16; bk_row_valid in cycles 2..17 with idx 0..15 and data = ROM rows; bk_done only in cycle 17.
- Interleave: same burst with rt_req=1 in cycles 4..7 → rows 3..15 slip 4 cycles; rt_valid in cycles 5..8; bk_done in cycle 21; no lost or duplicate rows.
- Ignored start: second bk_start (char 0x05) in cycle 10 of a burst → no effect; all rows are from 0x21; a start in cycle 18 is accepted.
- Reset mid-burst: reset_n=0 in cycle 9 → bk_busy and bk_row_valid drop immediately; no bk_done; a new burst after release runs the full 17-cycle sequence.
